// File: rtl/fetch_next_pc_unit_pkg.sv
// Shared constants and state encoding for the fetch / next-PC unit.
// Opcode and funct3 values follow the RV64I base encoding.
package fetch_next_pc_unit_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_JALR = 3'b000;

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_RESOLVE,
    S_ERROR
  } state_t;

endpackage

// File: rtl/fetch_next_pc_unit_next_pc_calc.sv
// Combinational next-PC resolution for branches, jal and jalr.
// All sums wrap modulo 2^XLEN.
module next_pc_calc
  import fetch_next_pc_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] pc,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] next_pc
);

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] rel_pc;
  logic [XLEN-1:0] jalr_sum;
  logic            taken;
  logic            is_jalr;

  assign seq_pc   = pc + XLEN'(4);
  assign rel_pc   = pc + imm;
  assign jalr_sum = rs1_data + imm;
  assign is_jalr  = (opcode == OP_JALR) && (funct3 == F3_JALR);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1_data == rs2_data);
      F3_BNE:  taken = (rs1_data != rs2_data);
      F3_BLT:  taken = ($signed(rs1_data) < $signed(rs2_data));
      F3_BGE:  taken = ($signed(rs1_data) >= $signed(rs2_data));
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    next_pc = seq_pc;
    unique case (1'b1)
      (opcode == OP_BRANCH): next_pc = taken ? rel_pc : seq_pc;
      (opcode == OP_JAL):    next_pc = rel_pc;
      is_jalr:               next_pc = {jalr_sum[XLEN-1:1], 1'b0};
      default:               next_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/fetch_next_pc_unit.sv
// Fetch stage: owns the PC, runs one instruction at a time through
// request, response, decoder handoff and execute-stage resolution.
module fetch_next_pc_unit
  import fetch_next_pc_unit_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  input  logic            imem_gnt,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            upd_valid,
  input  logic [6:0]      upd_opcode,
  input  logic [2:0]      upd_funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  output logic            misalign
);

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] next_pc;

  assign imem_addr = pc;

  next_pc_calc #(.XLEN(XLEN)) u_calc (
    .pc       (pc),
    .opcode   (upd_opcode),
    .funct3   (upd_funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .imm      (imm),
    .next_pc  (next_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      misalign   <= 1'b0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_gnt) begin
            imem_req <= 1'b0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            inst       <= imem_rdata;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            state      <= S_RESOLVE;
          end
        end
        S_RESOLVE: begin
          if (upd_valid) begin
            // A misaligned target parks the unit with the PC untouched.
            if (next_pc[1:0] != 2'b00) begin
              misalign <= 1'b1;
              state    <= S_ERROR;
            end else begin
              pc       <= next_pc;
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
          end
        end
        S_ERROR: begin
          imem_req <= 1'b0;
        end
        default: state <= S_ERROR;
      endcase
    end
  end

endmodule
